// File: rtl/de2i_150_qsys_nios2_oci_dct_packer_if.sv
// Frame output channel of the DCT packer: a single-entry valid/ready link
// carrying {count[3:0], buffer[29:0]} to the trace FIFO.
interface de2i_150_qsys_nios2_oci_dct_packer_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [33:0] frame_data;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/de2i_150_qsys_nios2_oci_dct_packer.sv
// DCT packer: shifts 2-bit branch outcome codes into a 15-entry (30-bit)
// accumulator and hands completed frames to a single-entry output register.
// Frames close when full, on flush, or on trc_on falling. Frames that arrive
// while the output register is stalled are dropped and counted in ovf_count.
// Optional macro DCT_PACKER_TIMEOUT_EN adds an idle-timeout frame close.
module de2i_150_qsys_nios2_oci_dct_packer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int OVF_W          = 8
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    trc_on,
  input  logic                                    dct_valid,
  input  logic [1:0]                              dct_code,
  input  logic                                    flush,
  de2i_150_qsys_nios2_oci_dct_packer_if.master    fo,
  output logic [29:0]                             dct_buffer,
  output logic [3:0]                              dct_count,
  output logic [OVF_W-1:0]                        ovf_count
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  logic [29:0]      buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             trc_on_prev_q, trc_on_prev_d;
  logic             frame_valid_q, frame_valid_d;
  logic [33:0]      frame_data_q, frame_data_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  logic             accept;
  logic [29:0]      next_buf;
  logic [3:0]       next_cnt;
  logic             timeout_hit;
  logic             emit;
  logic             load;

`ifdef DCT_PACKER_TIMEOUT_EN
  logic [7:0]       idle_q, idle_d;

  // Idle timer: restarts on every accept or emit, runs only while a partial
  // frame is pending.
  always_comb begin
    idle_d = idle_q;
    if (accept || emit) begin
      idle_d = 8'd0;
    end else if (cnt_q != 4'd0) begin
      idle_d = idle_q + 8'd1;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout_hit = (idle_q == TIMEOUT_LIM);
`else
  logic unused_timeout_lim;
  assign unused_timeout_lim = ^TIMEOUT_LIM;
  assign timeout_hit        = 1'b0;
`endif

  // Pack the incoming code, decide whether the frame closes, and update the
  // output register and overflow counter.
  always_comb begin
    accept        = trc_on && dct_valid && (dct_code != 2'b00);
    next_buf      = buf_q;
    next_cnt      = cnt_q;
    if (accept) begin
      next_buf = {buf_q[27:0], dct_code};
      next_cnt = cnt_q + 4'd1;
    end

    // Code is packed first, so a closing trigger includes this cycle's code.
    emit = (next_cnt == 4'd15) ||
           ((flush || (trc_on_prev_q && !trc_on) || timeout_hit) &&
            (next_cnt != 4'd0));
    load = emit && (!frame_valid_q || fo.frame_ready);

    buf_d         = emit ? 30'd0 : next_buf;
    cnt_d         = emit ? 4'd0 : next_cnt;
    trc_on_prev_d = trc_on;

    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    if (load) begin
      frame_valid_d = 1'b1;
      frame_data_d  = {next_cnt, next_buf};
    end else if (frame_valid_q && fo.frame_ready) begin
      frame_valid_d = 1'b0;
      frame_data_d  = 34'd0;
    end

    ovf_d = ovf_q;
    if (emit && frame_valid_q && !fo.frame_ready && (ovf_q != {OVF_W{1'b1}})) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  // State registers; reset discards any partial or held frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q         <= 30'd0;
      cnt_q         <= 4'd0;
      trc_on_prev_q <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= 34'd0;
      ovf_q         <= '0;
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      trc_on_prev_q <= trc_on_prev_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      ovf_q         <= ovf_d;
    end
  end

  assign fo.frame_valid = frame_valid_q;
  assign fo.frame_data  = frame_data_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign ovf_count      = ovf_q;

endmodule

// File: tb/tb_de2i_150_qsys_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer: full frames, flush, stalled output with
// overflow, trc_on falling close, asynchronous reset and idle timeout.
module tb_de2i_150_qsys_nios2_oci_dct_packer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       trc_on = 1'b0;
  logic       dct_valid = 1'b0;
  logic [1:0] dct_code = 2'b00;
  logic       flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  de2i_150_qsys_nios2_oci_dct_packer_if fif ();

  de2i_150_qsys_nios2_oci_dct_packer #(
    .TIMEOUT_CYCLES(4),
    .OVF_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .trc_on(trc_on),
    .dct_valid(dct_valid),
    .dct_code(dct_code),
    .flush(flush),
    .fo(fif.master),
    .dct_buffer(dct_buffer),
    .dct_count(dct_count),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      dct_valid = 1'b1;
      dct_code  = code;
      step();
    end
    dct_valid = 1'b0;
    dct_code  = 2'b00;
  endtask

  initial begin
    fif.frame_ready = 1'b1;
    #12;
    check("reset_valid", 64'(fif.frame_valid), 64'd0);
    check("reset_data",  64'(fif.frame_data),  64'd0);
    check("reset_count", 64'(dct_count),       64'd0);
    check("reset_buf",   64'(dct_buffer),      64'd0);
    check("reset_ovf",   64'(ovf_count),       64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    trc_on  = 1'b1;
    step();

    // Fifteen "taken" codes make one full frame.
    push(2'b10, 14);
    check("full_cnt14", 64'(dct_count),  64'd14);
    check("full_buf14", 64'(dct_buffer), 64'h0AAAAAAA);
    check("full_nv14",  64'(fif.frame_valid), 64'd0);
    push(2'b10, 1);
    check("full_valid", 64'(fif.frame_valid), 64'd1);
    check("full_data",  64'(fif.frame_data),  64'({4'hF, 30'h2AAAAAAA}));
    check("full_clear", 64'(dct_count),       64'd0);
    step();
    check("full_gone",  64'(fif.frame_valid), 64'd0);

    // Illegal code is ignored.
    push(2'b00, 1);
    check("illegal_cnt", 64'(dct_count), 64'd0);

    // Flush together with a 4th code.
    push(2'b01, 1);
    push(2'b10, 1);
    push(2'b01, 1);
    check("flush_cnt3", 64'(dct_count),  64'd3);
    check("flush_buf3", 64'(dct_buffer), 64'h19);
    dct_valid = 1'b1; dct_code = 2'b10; flush = 1'b1;
    step();
    dct_valid = 1'b0; dct_code = 2'b00;
    check("flush_valid", 64'(fif.frame_valid), 64'd1);
    check("flush_data",  64'(fif.frame_data),  64'({4'd4, 30'h66}));
    step();
    flush = 1'b0;
    check("flush_empty", 64'(fif.frame_valid), 64'd0);
    check("flush_ovf0",  64'(ovf_count),       64'd0);

    // Stalled output: second full frame is dropped.
    fif.frame_ready = 1'b0;
    push(2'b01, 15);
    check("stall_valid1", 64'(fif.frame_valid), 64'd1);
    push(2'b11, 15);
    check("stall_held",  64'(fif.frame_data), 64'({4'hF, 30'h15555555}));
    check("stall_ovf",   64'(ovf_count),      64'd1);
    check("stall_cnt",   64'(dct_count),      64'd0);
    check("stall_valid2", 64'(fif.frame_valid), 64'd1);
    fif.frame_ready = 1'b1;
    step();
    check("stall_drain", 64'(fif.frame_valid), 64'd0);

    // trc_on falling closes a partial frame; codes ignored while off.
    push(2'b10, 5);
    check("trc_cnt5", 64'(dct_count), 64'd5);
    trc_on = 1'b0; dct_valid = 1'b1; dct_code = 2'b01;
    step();
    check("trc_valid", 64'(fif.frame_valid), 64'd1);
    check("trc_data",  64'(fif.frame_data),  64'({4'd5, 30'h2AA}));
    step();
    check("trc_ignore", 64'(dct_count),       64'd0);
    check("trc_novalid", 64'(fif.frame_valid), 64'd0);
    dct_valid = 1'b0; dct_code = 2'b00;
    trc_on = 1'b1;
    step();

    // Asynchronous reset mid-accumulation.
    push(2'b01, 7);
    check("rst_cnt7", 64'(dct_count), 64'd7);
    #2 reset_n = 1'b0;
    #1;
    check("rst_acc_cnt", 64'(dct_count),  64'd0);
    check("rst_acc_buf", 64'(dct_buffer), 64'd0);
    check("rst_acc_ovf", 64'(ovf_count),  64'd0);
    step();
    reset_n = 1'b1;
    step();
    check("rst_acc_nf", 64'(fif.frame_valid), 64'd0);

    // Asynchronous reset while a frame is held.
    fif.frame_ready = 1'b0;
    push(2'b10, 15);
    check("rst_hold_v", 64'(fif.frame_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_hold_v0", 64'(fif.frame_valid), 64'd0);
    check("rst_hold_d0", 64'(fif.frame_data),  64'd0);
    step();
    reset_n = 1'b1;
    fif.frame_ready = 1'b1;
    step();
    step();
    check("rst_hold_nf", 64'(fif.frame_valid), 64'd0);

    // Idle timeout (TIMEOUT_CYCLES = 4).
    push(2'b10, 1);
    push(2'b01, 1);
    check("to_cnt2", 64'(dct_count), 64'd2);
    for (int i = 0; i < 5; i++) step();
`ifdef DCT_PACKER_TIMEOUT_EN
    check("to_valid", 64'(fif.frame_valid), 64'd1);
    check("to_data",  64'(fif.frame_data),  64'({4'd2, 30'h9}));
    check("to_cnt0",  64'(dct_count),       64'd0);
`else
    check("to_none",  64'(fif.frame_valid), 64'd0);
    check("to_keep",  64'(dct_count),       64'd2);
    check("to_buf",   64'(dct_buffer),      64'h9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
